// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, frame geometry and
// the clock/baud constants also used by the baud rate generator.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam int unsigned UART_DATA_BITS = 8;
  localparam int unsigned UART_BIT_CNT_W = $clog2(UART_DATA_BITS);

  localparam int unsigned UART_BAUD_RATE = 115_200;
  localparam int unsigned UART_CLK_HZ    = 50_000_000;

  // Nearest-integer clocks per bit for a given clock and baud rate.
  function automatic int unsigned baud_div(input int unsigned clk_hz,
                                           input int unsigned baud);
    return (clk_hz + (baud / 2)) / baud;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Searches ptr_i+1, ptr_i+2, ... modulo N and grants the first active request.
// The pointer register is owned by the instantiating block.
//   req_i  : request vector
//   ptr_i  : index of the previous winner (lowest priority this round)
//   en_i   : arbitration enable; when low no grant is produced
//   gnt_o  : one-hot grant (all zero when disabled or nothing requested)
//   idx_o  : encoded index of the granted request (0 when no grant)
module rr_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  input  logic             en_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o
);

  logic             found;
  logic [IDX_W-1:0] cand;

  // Walk the rotated priority order; the first hit wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = IDX_W'((32'(ptr_i) + k) % N);
      if (en_i && !found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin shared 8N1 UART transmitter.
// NUM_REQ requesters offer bytes over valid/ready; one byte is framed per
// grant. Every state change is paced by the txclk_en bit strobe.
//   clk_50m   : system clock
//   rst_n     : asynchronous active-low reset
//   txclk_en  : one-cycle bit-period strobe
//   req_valid : per-requester byte valid
//   req_data  : requester i byte at [8*i+7:8*i]
//   req_ready : one-hot accept strobe (combinational, only at grant points)
//   tx        : registered serial line, idles high
//   busy      : high while a frame is on the line
//   grant_id  : owner of the current or most recent frame
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int unsigned NUM_REQ   = 4,
  localparam int unsigned GID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic                                clk_50m,
  input  logic                                rst_n,
  input  logic                                txclk_en,
  input  logic [NUM_REQ-1:0]                  req_valid,
  input  logic [NUM_REQ*UART_DATA_BITS-1:0]   req_data,
  output logic [NUM_REQ-1:0]                  req_ready,
  output logic                                tx,
  output logic                                busy,
  output logic [GID_WIDTH-1:0]                grant_id
);

  localparam logic [UART_BIT_CNT_W-1:0] LAST_BIT = UART_BIT_CNT_W'(UART_DATA_BITS - 1);

  tx_state_e                   state_q, state_d;
  logic [UART_DATA_BITS-1:0]   shift_q, shift_d;
  logic [UART_BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic                        tx_q, tx_d;
  logic                        busy_q, busy_d;
  logic [GID_WIDTH-1:0]        gid_q, gid_d;
  logic [GID_WIDTH-1:0]        last_q, last_d;

  logic                        grant_pt;
  logic [NUM_REQ-1:0]          gnt;
  logic [GID_WIDTH-1:0]        gnt_idx;
  logic                        gnt_any;
  logic [UART_DATA_BITS-1:0]   gnt_byte;

  // Grant point: bit boundary while the line is idle or showing the stop bit.
  // Gated by rst_n so no handshake can complete while reset is held.
  assign grant_pt = rst_n && txclk_en && ((state_q == IDLE) || (state_q == STOP));

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (GID_WIDTH)
  ) u_rr_arbiter (
    .req_i (req_valid),
    .ptr_i (last_q),
    .en_i  (grant_pt),
    .gnt_o (gnt),
    .idx_o (gnt_idx)
  );

  assign gnt_any   = |gnt;
  assign req_ready = gnt;

  // One-hot byte select of the winning requester.
  always_comb begin
    gnt_byte = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        gnt_byte = req_data[UART_DATA_BITS*i +: UART_DATA_BITS];
      end
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    gid_d     = gid_q;
    last_d    = last_q;

    unique case (state_q)
      IDLE, STOP: begin
        if (gnt_any) begin
          // Back-to-back from STOP: no idle bit is inserted.
          shift_d = gnt_byte;
          gid_d   = gnt_idx;
          last_d  = gnt_idx;
          state_d = START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end else if (txclk_en) begin
          state_d = IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
        end
      end
      START: begin
        if (txclk_en) begin
          tx_d      = shift_q[0];
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (txclk_en) begin
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + UART_BIT_CNT_W'(1);
          if (bit_cnt_q == LAST_BIT) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            tx_d = shift_q[1];
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      gid_q     <= '0;
      last_q    <= GID_WIDTH'(NUM_REQ - 1);
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      gid_q     <= gid_d;
      last_q    <= last_d;
    end
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign grant_id = gid_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: a table-driven single-byte frame,
// hand-written corner sequences, and a randomized run against a queue model.
module tb_uart_tx_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned GW = 2;

  logic            clk_50m = 1'b0;
  logic            rst_n;
  logic            txclk_en;
  logic [N-1:0]    req_valid;
  logic [8*N-1:0]  req_data;
  logic [N-1:0]    req_ready;
  logic            tx;
  logic            busy;
  logic [GW-1:0]   grant_id;

  int checks = 0;
  int errors = 0;

  uart_tx_arbiter #(.NUM_REQ(N)) dut (
    .clk_50m   (clk_50m),
    .rst_n     (rst_n),
    .txclk_en  (txclk_en),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .tx        (tx),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  always #10 clk_50m = ~clk_50m;

  typedef struct {
    logic [N-1:0]  valid;
    logic [7:0]    data;
    logic [N-1:0]  exp_ready;
    logic          exp_tx;
    logic          exp_busy;
    logic [GW-1:0] exp_gid;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge: drive strobe, sample ready, advance to next negedge.
  task automatic step(input logic en, output logic [N-1:0] rdy);
    txclk_en = en;
    #1;
    rdy = req_ready;
    @(posedge clk_50m);
    @(negedge clk_50m);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    txclk_en  = 1'b0;
    req_valid = '0;
    req_data  = '0;
    repeat (2) @(negedge clk_50m);
    rst_n = 1'b1;
  endtask

  // Reference rule: search last+1, last+2, ... modulo N.
  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= int'(N); k++) begin
      if (v[(last + k) % int'(N)]) return (last + k) % int'(N);
    end
    return -1;
  endfunction

  initial begin
    #10_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] rdy;
    logic [7:0]   byt;
    int           exp_bits[$];
    int           found;

    // ---------------- reset state ----------------
    do_reset();
    #1;
    chk("rst_tx", 32'(tx), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_gid", 32'(grant_id), 0);
    chk("rst_ready", 32'(req_ready), 0);

    // ---------------- single byte 0xA5, strobe every 4th cycle ----------------
    tbl[0]  = '{4'b0001, 8'hA5, 4'b0001, 1'b0, 1'b1, 2'd0};
    tbl[1]  = '{4'b0000, 8'h00, 4'b0000, 1'b1, 1'b1, 2'd0};
    tbl[2]  = '{4'b0000, 8'h00, 4'b0000, 1'b0, 1'b1, 2'd0};
    tbl[3]  = '{4'b0000, 8'h00, 4'b0000, 1'b1, 1'b1, 2'd0};
    tbl[4]  = '{4'b0000, 8'h00, 4'b0000, 1'b0, 1'b1, 2'd0};
    tbl[5]  = '{4'b0000, 8'h00, 4'b0000, 1'b0, 1'b1, 2'd0};
    tbl[6]  = '{4'b0000, 8'h00, 4'b0000, 1'b1, 1'b1, 2'd0};
    tbl[7]  = '{4'b0000, 8'h00, 4'b0000, 1'b0, 1'b1, 2'd0};
    tbl[8]  = '{4'b0000, 8'h00, 4'b0000, 1'b1, 1'b1, 2'd0};
    tbl[9]  = '{4'b0000, 8'h00, 4'b0000, 1'b1, 1'b1, 2'd0};
    tbl[10] = '{4'b0000, 8'h00, 4'b0000, 1'b1, 1'b0, 2'd0};
    foreach (tbl[i]) begin
      req_valid     = tbl[i].valid;
      req_data[7:0] = tbl[i].data;
      repeat (3) begin
        step(1'b0, rdy);
        chk($sformatf("sb_noready[%0d]", i), 32'(rdy), 0);
      end
      step(1'b1, rdy);
      chk($sformatf("sb_ready[%0d]", i), 32'(rdy), 32'(tbl[i].exp_ready));
      chk($sformatf("sb_tx[%0d]", i), 32'(tx), 32'(tbl[i].exp_tx));
      chk($sformatf("sb_busy[%0d]", i), 32'(busy), 32'(tbl[i].exp_busy));
      chk($sformatf("sb_gid[%0d]", i), 32'(grant_id), 32'(tbl[i].exp_gid));
    end

    // ---------------- round-robin fairness, one bit per clock ----------------
    do_reset();
    req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    req_valid = 4'hF;
    for (int f = 0; f < 5; f++) begin
      byt = 8'h10 + 8'(f % 4);
      exp_bits.push_back(0);
      for (int b = 0; b < 8; b++) exp_bits.push_back(int'(byt[b]));
      exp_bits.push_back(1);
    end
    for (int c = 0; c < 50; c++) begin
      step(1'b1, rdy);
      chk($sformatf("rr_ready[%0d]", c), 32'(rdy),
          (c % 10 == 0) ? (32'd1 << ((c / 10) % 4)) : 32'd0);
      chk($sformatf("rr_tx[%0d]", c), 32'(tx), 32'(exp_bits[c]));
      chk($sformatf("rr_busy[%0d]", c), 32'(busy), 1);
      chk($sformatf("rr_gid[%0d]", c), 32'(grant_id), 32'((c / 10) % 4));
    end

    // ---------------- pointer wrap: last=3, requesters 1 and 3 ----------------
    req_valid = 4'b1000;
    found = 0;
    for (int c = 0; c < 12 && found == 0; c++) begin
      step(1'b1, rdy);
      if (rdy != 0) begin
        found = 1;
        chk("wrap_setup_ready", 32'(rdy), 32'b1000);
      end
    end
    chk("wrap_setup_seen", 32'(found), 1);
    req_valid = 4'b1010;
    found = 0;
    for (int c = 0; c < 12 && found == 0; c++) begin
      step(1'b1, rdy);
      if (rdy != 0) begin
        found = 1;
        chk("wrap_ready", 32'(rdy), 32'b0010);
        chk("wrap_gid", 32'(grant_id), 1);
      end
    end
    chk("wrap_seen", 32'(found), 1);

    // ---------------- gating: no strobe for 100 cycles ----------------
    do_reset();
    req_valid        = 4'b0100;
    req_data[23:16]  = 8'hC3;
    for (int c = 0; c < 100; c++) begin
      step(1'b0, rdy);
      chk("gate_ready", 32'(rdy), 0);
      chk("gate_tx", 32'(tx), 1);
      chk("gate_busy", 32'(busy), 0);
    end
    step(1'b1, rdy);
    chk("gate_grant_ready", 32'(rdy), 32'b0100);
    chk("gate_grant_tx", 32'(tx), 0);
    chk("gate_grant_busy", 32'(busy), 1);
    chk("gate_grant_gid", 32'(grant_id), 2);

    // ---------------- reset mid-frame during data bit 3 ----------------
    req_valid = '0;
    repeat (4) step(1'b1, rdy);
    chk("mid_tx_bit3", 32'(tx), 0);
    req_valid = 4'b0101;
    txclk_en  = 1'b1;
    rst_n     = 1'b0;
    #1;
    chk("mid_rst_tx", 32'(tx), 1);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_ready", 32'(req_ready), 0);
    @(posedge clk_50m);
    @(negedge clk_50m);
    rst_n = 1'b1;
    step(1'b1, rdy);
    chk("mid_after_ready", 32'(rdy), 32'b0001);
    chk("mid_after_gid", 32'(grant_id), 0);
    chk("mid_after_tx", 32'(tx), 0);

    // ---------------- withdrawn request ----------------
    do_reset();
    req_valid = 4'b0010;
    repeat (5) step(1'b0, rdy);
    req_valid = '0;
    for (int c = 0; c < 3; c++) begin
      step(1'b1, rdy);
      chk("wd_ready", 32'(rdy), 0);
      chk("wd_tx", 32'(tx), 1);
      chk("wd_busy", 32'(busy), 0);
    end
    req_valid = 4'b0011;
    step(1'b1, rdy);
    chk("wd_next_ready", 32'(rdy), 32'b0001);

    // ---------------- randomized run against queue model ----------------
    begin
      int           q[$];
      int           m_tx, m_busy, m_gid, m_last, w;
      logic [N-1:0] acc, exp_r;
      logic         en;
      do_reset();
      q.delete();
      m_tx = 1; m_busy = 0; m_gid = 0; m_last = int'(N) - 1;
      acc = '0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        chk("rnd_tx", 32'(tx), 32'(m_tx));
        chk("rnd_busy", 32'(busy), 32'(m_busy));
        chk("rnd_gid", 32'(grant_id), 32'(m_gid));
        req_valid = req_valid & ~acc;
        for (int i = 0; i < int'(N); i++) begin
          if (!req_valid[i]) begin
            if ($urandom_range(0, 3) == 0) begin
              req_valid[i]       = 1'b1;
              req_data[8*i +: 8] = 8'($urandom);
            end
          end else if ($urandom_range(0, 63) == 0) begin
            req_valid[i] = 1'b0;
          end
        end
        en = ((cyc / 250) % 3 == 2) ? 1'b1 : ($urandom_range(0, 2) == 0);
        txclk_en = en;
        #1;
        w = (en && q.size() == 0) ? rr_pick(req_valid, m_last) : -1;
        exp_r = (w >= 0) ? (N'(1) << w) : '0;
        chk($sformatf("rnd_ready@%0d", cyc), 32'(req_ready), 32'(exp_r));
        if (w >= 0) byt = req_data[8*w +: 8];
        @(posedge clk_50m);
        if (en) begin
          if (q.size() == 0) begin
            if (w >= 0) begin
              for (int b = 0; b < 8; b++) q.push_back(int'(byt[b]));
              q.push_back(1);
              m_tx = 0; m_busy = 1; m_gid = w; m_last = w;
            end else begin
              m_tx = 1; m_busy = 0;
            end
          end else begin
            m_tx = q.pop_front();
          end
        end
        acc = exp_r;
        @(negedge clk_50m);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
